// File: rtl/button_press_encoder.sv
// Five-button front end: synchronise, debounce, and turn each new press into a one-cycle command code.
// Optional auto-repeat for nxt/ris while held is enabled by defining AUTO_REPEAT_EN.
module button_press_encoder #(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] btn_i,
   output logic [2:0] press_o,
   output logic [4:0] held_o
);

   localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]      CODE_NONE = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_HELD = 2'd2
   } state_t;

   // Simultaneous rises resolve as rls > del > ris > con > nxt.
   function automatic logic [2:0] encode_rise(input logic [4:0] r);
      if (r[1])      encode_rise = 3'b001;
      else if (r[3]) encode_rise = 3'b011;
      else if (r[4]) encode_rise = 3'b100;
      else if (r[2]) encode_rise = 3'b010;
      else if (r[0]) encode_rise = 3'b000;
      else           encode_rise = CODE_NONE;
   endfunction

   logic [4:0]      sync1_r;
   logic [4:0]      sync2_r;
   logic [DB_W-1:0] db_cnt_r [5];
   logic [4:0]      held_r;
   logic [4:0]      held_d_r;
   logic [4:0]      rise_s;
   state_t          state_r;
   state_t          state_next_s;
   logic [2:0]      code_r;
   logic [2:0]      code_next_s;
   logic [2:0]      press_r;
   logic [2:0]      press_next_s;
   logic            rep_fire_s;

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 5'b00000;
         sync2_r <= 5'b00000;
      end else begin
         sync1_r <= btn_i;
         sync2_r <= sync1_r;
      end
   end

   // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 5; k++) begin
            db_cnt_r[k] <= '0;
         end
         held_r   <= 5'b00000;
         held_d_r <= 5'b00000;
      end else begin
         held_d_r <= held_r;
         for (int k = 0; k < 5; k++) begin
            if (sync2_r[k] == held_r[k]) begin
               db_cnt_r[k] <= '0;
            end else if (db_cnt_r[k] >= DB_LAST) begin
               held_r[k]   <= ~held_r[k];
               db_cnt_r[k] <= '0;
            end else begin
               db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
            end
         end
      end
   end

   assign rise_s = held_r & ~held_d_r;

`ifdef AUTO_REPEAT_EN
   localparam int              REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int              REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_SAT = REP_W'(REP_MAX);

   logic [REP_W-1:0] rep_cnt_r;
   logic             rep_first_r;
   logic             rep_ok_s;

   // Only a stable lone nxt or ris, matching the emitted code, may repeat.
   assign rep_ok_s = (state_r == S_HELD) && (held_r == held_d_r) &&
                     (((held_r == 5'b00001) && (code_r == 3'b000)) ||
                      ((held_r == 5'b10000) && (code_r == 3'b100)));
   assign rep_fire_s = rep_ok_s &&
                       (rep_first_r ? (rep_cnt_r == REP_W'(REPEAT_PERIOD))
                                    : (rep_cnt_r == REP_W'(REPEAT_DELAY)));

   // Repeat timer; restarts at 1 on a pulse so later pulses land exactly REPEAT_PERIOD apart.
   always_ff @(posedge clk) begin
      if (rst || !rep_ok_s) begin
         rep_cnt_r   <= '0;
         rep_first_r <= 1'b0;
      end else if (rep_fire_s) begin
         rep_cnt_r   <= REP_W'(1);
         rep_first_r <= 1'b1;
      end else if (rep_cnt_r != REP_SAT) begin
         rep_cnt_r   <= rep_cnt_r + REP_W'(1);
      end else begin
         rep_cnt_r   <= rep_cnt_r;
      end
   end
`else
   assign rep_fire_s = 1'b0;
   if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_repeat_unused
   end
`endif

   // State, latched code and registered command output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         code_r  <= CODE_NONE;
         press_r <= CODE_NONE;
      end else begin
         state_r <= state_next_s;
         code_r  <= code_next_s;
         press_r <= press_next_s;
      end
   end

   // Next-state and next-output decode: one command per gesture.
   always_comb begin
      state_next_s = state_r;
      code_next_s  = code_r;
      press_next_s = CODE_NONE;
      case (state_r)
         S_IDLE: begin
            if ((rise_s != 5'b00000) && ((held_r & ~rise_s) == 5'b00000)) begin
               state_next_s = S_EMIT;
               code_next_s  = encode_rise(rise_s);
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_EMIT: begin
            press_next_s = code_r;
            state_next_s = S_HELD;
         end
         S_HELD: begin
            if (held_r == 5'b00000) begin
               state_next_s = S_IDLE;
            end else if (rep_fire_s) begin
               press_next_s = code_r;
            end else begin
               press_next_s = CODE_NONE;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   assign press_o = press_r;
   assign held_o  = held_r;

endmodule

// File: tb/tb_button_press_encoder.sv
// Scoreboard bench for button_press_encoder: stimulus queues expected (code, cycle) pairs,
// a negedge monitor pops one entry for every non-idle press_o it sees.
module tb_button_press_encoder;

   localparam int DB  = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;
   localparam int LAT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn = 5'b00000;
   logic [2:0] press;
   logic [4:0] held;

   typedef struct {
      logic [2:0] code;
      int         at;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   asserts  = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   button_press_encoder #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn),
      .press_o(press),
      .held_o (held)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      asserts++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_press(input logic [2:0] code, input int at);
      exp_t e;
      e.code = code;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every non-idle output must match the oldest expected pulse, in code and cycle.
   always @(negedge clk) begin
      if (press !== 3'b111) begin
         if (exp_q.size() == 0) begin
            check("unexpected_press", 32'(press), 32'd7);
         end else begin
            mon_e = exp_q.pop_front();
            check("press_code", 32'(press), 32'(mon_e.code));
            check("press_cycle", 32'(cyc), 32'(mon_e.at));
         end
      end
   end

   initial begin
      int t0;

      // 1: reset and idle
      step(3);
      check("reset_press", 32'(press), 32'd7);
      check("reset_held", 32'(held), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("idle_press", 32'(press), 32'd7);
         check("idle_held", 32'(held), 32'd0);
      end

      // 2: con press, debounce boundaries on press and release
      t0  = cyc;
      btn = 5'b00100;
      expect_press(3'b010, t0 + LAT);
      step(5);
      check("db_rise_early", 32'(held), 32'd0);
      step(1);
      check("db_rise_accept", 32'(held), 32'b00100);
      step(24);
      btn = 5'b00000;
      step(5);
      check("db_fall_early", 32'(held), 32'b00100);
      step(1);
      check("db_fall_accept", 32'(held), 32'd0);
      step(10);

      // 3: 3-cycle glitches on rls never reach held_o
      for (int g = 0; g < 5; g++) begin
         btn = 5'b00010;
         for (int i = 0; i < 3; i++) begin
            step(1);
            check("glitch_held", 32'(held), 32'd0);
         end
         btn = 5'b00000;
         for (int i = 0; i < 3; i++) begin
            step(1);
            check("glitch_held", 32'(held), 32'd0);
         end
      end
      step(10);

      // 4: rls and del together, rls wins; dropping rls alone gives nothing
      t0  = cyc;
      btn = 5'b01010;
      expect_press(3'b001, t0 + LAT);
      step(20);
      check("both_held", 32'(held), 32'b01010);
      btn = 5'b01000;
      step(20);
      check("del_still_held", 32'(held), 32'b01000);
      btn = 5'b00000;
      step(15);

      // 5: long nxt hold
      t0  = cyc;
      btn = 5'b00001;
      expect_press(3'b000, t0 + LAT);
`ifdef AUTO_REPEAT_EN
      expect_press(3'b000, t0 + 29);
      expect_press(3'b000, t0 + 37);
      expect_press(3'b000, t0 + 45);
      expect_press(3'b000, t0 + 53);
      // released early enough that held_o drops before the +61 repeat would fire
      step(54);
`else
      step(60);
`endif
      btn = 5'b00000;
      step(15);

      // 6: reset while holding ris; the held button re-debounces from the reset edge
      t0  = cyc;
      btn = 5'b10000;
      expect_press(3'b100, t0 + LAT);
      step(15);
      rst = 1'b1;
      expect_press(3'b100, cyc + 1 + LAT);
      step(1);
      check("rst_held_press", 32'(press), 32'd7);
      check("rst_held_held", 32'(held), 32'd0);
      rst = 1'b0;
      step(20);
      check("ris_reheld", 32'(held), 32'b10000);
      btn = 5'b00000;
      step(15);

      check("pending_pulses", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
